// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the 5-bit character codes they decode to.
package seg_pkg;

  localparam int NumDigits = 4;

  typedef logic [6:0] seg_pat_t;
  typedef logic [4:0] char_code_t;
  typedef logic [NumDigits-1:0][6:0] frame_t;
  typedef logic [NumDigits-1:0][4:0] code_frame_t;

  // Index h holds the active-low pattern of hex digit h.
  localparam seg_pat_t SegHex [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam seg_pat_t SegL     = 7'h47;
  localparam seg_pat_t SegBlank = 7'h7F;
  localparam frame_t   FrameBlank = {NumDigits{SegBlank}};

  localparam char_code_t CodeOne   = 5'd1;
  localparam char_code_t CodeA     = 5'd10;
  localparam char_code_t CodeF     = 5'd15;
  localparam char_code_t CodeL     = 5'd16;
  localparam char_code_t CodeBlank = 5'd17;
  localparam char_code_t CodeBad   = 5'd31;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed seven-segment display scan and its decoder.
interface seg_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [27:0] digits;
  logic [19:0] codes;
  logic        frame_valid;
  logic        fail_seen;
  logic        anode_err;

  modport master (
    output an, seg,
    input  digits, codes, frame_valid, fail_seen, anode_err
  );
  modport slave (
    input  an, seg,
    output digits, codes, frame_valid, fail_seen, anode_err
  );
endinterface

// File: rtl/seg_char_decode.sv
// Purely combinational map from one active-low segment pattern to its character code.
module seg_char_decode
  import seg_pkg::*;
(
  input  seg_pat_t   pat_i,
  output char_code_t code_o
);
  always_comb begin
    code_o = CodeBad;
    if (pat_i == SegL) begin
      code_o = CodeL;
    end else if (pat_i == SegBlank) begin
      code_o = CodeBlank;
    end else begin
      for (int h = 0; h < 16; h++) begin
        if (pat_i == SegHex[h]) code_o = 5'(h);
      end
    end
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a 4-digit multiplexed LED scan, rebuilds the displayed frame and
// publishes it once it has been seen unchanged for STABLE_FRAMES frames.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input logic               clock,
  input logic               reset,
  seg_scan_decoder_if.slave bus
);
  localparam logic [3:0] Settle = 4'(SETTLE_CYCLES);
  localparam logic [2:0] Stable = 3'(STABLE_FRAMES);

  logic [3:0]           an_q, prev_an_q;
  seg_pat_t             seg_q;
  logic [3:0]           dwell_q, dwell_d;
  logic [NumDigits-1:0] mark_q, mark_d;
  frame_t               shadow_q, shadow_d, frame_q, frame_d, digit_q, digit_d;
  logic [2:0]           match_q, match_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic                 single, multi, restart, capture, complete, load;
  logic [1:0]           slot;
  code_frame_t          code_w;

  always_comb begin
    single  = $onehot(~an_q);
    multi   = (an_q != 4'hF) && !single;
    restart = (an_q != prev_an_q);
    slot    = 2'd0;
    for (int i = 0; i < NumDigits; i++) begin
      if (!an_q[i]) slot = 2'(i);
    end

    dwell_d = dwell_q;
    if (!single)                dwell_d = 4'd0;
    else if (restart)           dwell_d = 4'd1;
    else if (dwell_q != 4'hF)   dwell_d = dwell_q + 4'd1;
    // Only the cycle the count first reaches Settle samples, even when saturated.
    capture = single && (dwell_d == Settle) && (restart || dwell_q != Settle);

    complete = &mark_q;
    mark_d   = complete ? '0 : mark_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    match_d  = match_q;
    if (complete) begin
      frame_d = shadow_q;
      if (shadow_q == frame_q) match_d = (match_q == Stable) ? match_q : match_q + 3'd1;
      else                     match_d = 3'd1;
    end
    if (capture) begin
      shadow_d[slot] = seg_q;
      mark_d[slot]   = 1'b1;
    end

    load    = (match_q == Stable) && (frame_q != digit_q);
    digit_d = load ? frame_q : digit_q;
    valid_d = load;
    err_d   = err_q | multi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_q      <= 4'hF;
      prev_an_q <= 4'hF;
      seg_q     <= SegBlank;
      dwell_q   <= 4'd0;
      mark_q    <= '0;
      shadow_q  <= FrameBlank;
      frame_q   <= FrameBlank;
      match_q   <= 3'd0;
      digit_q   <= FrameBlank;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      an_q      <= bus.an;
      prev_an_q <= an_q;
      seg_q     <= bus.seg;
      dwell_q   <= dwell_d;
      mark_q    <= mark_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      match_q   <= match_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < NumDigits; i++) begin : g_dec
    seg_char_decode u_dec (
      .pat_i  (digit_q[i]),
      .code_o (code_w[i])
    );
  end

  assign bus.digits      = digit_q;
  assign bus.codes       = code_w;
  assign bus.frame_valid = valid_q;
  assign bus.anode_err   = err_q;
  assign bus.fail_seen   = (code_w == {CodeF, CodeA, CodeOne, CodeL});
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed scan stimulus checked cycle by cycle against a
// frame-level behavioural model of the display snooper.
module tb_seg_scan_decoder;
  localparam int Settle = 4;
  localparam int Stable = 2;
  localparam int Lat    = 3;  // sampled input -> published frame, in clock edges

  // 0-F, L, blank
  localparam logic [6:0] PatTab [18] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1000111, 7'b1111111
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .SETTLE_CYCLES (Settle),
    .STABLE_FRAMES (Stable)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int obs_pulses = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_code(input logic [6:0] p);
    for (int c = 0; c < 18; c++) begin
      if (p == PatTab[c]) return 5'(c);
    end
    return 5'd31;
  endfunction

  function automatic logic [19:0] ref_codes(input logic [27:0] f);
    logic [19:0] r;
    for (int d = 0; d < 4; d++) r[d*5 +: 5] = ref_code(f[d*7 +: 7]);
    return r;
  endfunction

  // Reference model: run-length of the sampled anode, per-digit capture slots,
  // a stability count over whole frames and the published frame.
  logic [3:0]  m_prev;
  int          m_run, m_match;
  logic [27:0] m_shadow, m_last, m_disp;
  bit          m_marked [4];
  bit          m_pulse, m_err;
  logic [27:0] h_dig [Lat];
  bit          h_pul [Lat];
  bit          h_err [Lat];
  logic [27:0] e_digits;
  bit          e_pulse, e_err;

  task automatic model_reset();
    m_prev = 4'hF; m_run = 0; m_match = 0;
    m_shadow = '1; m_last = '1; m_disp = '1;
    m_pulse = 0; m_err = 0;
    for (int d = 0; d < 4; d++) m_marked[d] = 0;
    for (int i = 0; i < Lat; i++) begin h_dig[i] = '1; h_pul[i] = 0; h_err[i] = 0; end
    e_digits = '1; e_pulse = 0; e_err = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    int lows = 0;
    int idx = 0;
    bit all;
    e_digits = h_dig[0];
    e_pulse  = h_pul[0];
    e_err    = h_err[Lat-1];
    for (int d = 0; d < 4; d++) if (!a[d]) begin lows++; idx = d; end
    m_pulse = 0;
    if (lows > 1) m_err = 1;
    m_run  = (lows != 1) ? 0 : ((a == m_prev) ? m_run + 1 : 1);
    m_prev = a;
    if (lows == 1 && m_run == Settle) begin
      m_shadow[idx*7 +: 7] = s;
      m_marked[idx] = 1;
    end
    all = m_marked[0] && m_marked[1] && m_marked[2] && m_marked[3];
    if (all) begin
      m_match = (m_shadow == m_last) ? ((m_match < Stable) ? m_match + 1 : Stable) : 1;
      m_last  = m_shadow;
      for (int d = 0; d < 4; d++) m_marked[d] = 0;
      if (m_match == Stable && m_last != m_disp) begin
        m_disp  = m_last;
        m_pulse = 1;
      end
    end
    for (int i = 0; i < Lat - 1; i++) begin
      h_dig[i] = h_dig[i+1]; h_pul[i] = h_pul[i+1]; h_err[i] = h_err[i+1];
    end
    h_dig[Lat-1] = m_disp; h_pul[Lat-1] = m_pulse; h_err[Lat-1] = m_err;
  endtask

  task automatic tick(input logic [3:0] a, input logic [6:0] s, input bit r);
    @(negedge clk);
    bus.an = a; bus.seg = s; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(a, s);
    #1;
    check_eq("digits", bus.digits, e_digits);
    check_eq("codes", bus.codes, ref_codes(e_digits));
    check_eq("frame_valid", bus.frame_valid, e_pulse);
    check_eq("fail_seen", bus.fail_seen, ref_codes(e_digits) == {5'd15, 5'd10, 5'd1, 5'd16});
    check_eq("anode_err", bus.anode_err, e_err);
    if (bus.frame_valid) obs_pulses++;
  endtask

  function automatic logic [3:0] an_sel(input int d);
    logic [3:0] one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic scan_round(input logic [27:0] f, input int dw);
    for (int d = 3; d >= 0; d--) repeat (dw) tick(an_sel(d), f[d*7 +: 7], 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'hF, 7'h7F, 0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(4'hF, 7'h7F, 1);
  endtask

  logic [27:0] fr;
  logic [3:0]  ra;

  initial begin
    bus.an = 4'hF; bus.seg = 7'h7F;
    do_reset(3);
    check_eq("rst_digits", bus.digits, 28'hFFFFFFF);
    check_eq("rst_codes", bus.codes, {4{5'd17}});

    // F,A,I,L: one publish, fail_seen
    obs_pulses = 0;
    fr = {PatTab[15], PatTab[10], PatTab[1], PatTab[16]};
    scan_round(fr, 8); scan_round(fr, 8); idle(6);
    check_eq("fail_pulses", obs_pulses, 1);
    check_eq("fail_codes", bus.codes, {5'd15, 5'd10, 5'd1, 5'd16});
    check_eq("fail_seen_set", bus.fail_seen, 1);

    // 0,1,2,3 then digit 0 becomes 4
    obs_pulses = 0;
    fr = {PatTab[0], PatTab[1], PatTab[2], PatTab[3]};
    scan_round(fr, 8); scan_round(fr, 8); idle(4);
    check_eq("c0123_pulses", obs_pulses, 1);
    check_eq("c0123_codes", bus.codes, {5'd0, 5'd1, 5'd2, 5'd3});
    fr[6:0] = PatTab[4];
    scan_round(fr, 8); idle(4);
    check_eq("c0124_one_frame", obs_pulses, 1);
    scan_round(fr, 8); idle(4);
    check_eq("c0124_pulses", obs_pulses, 2);
    check_eq("c0124_codes", bus.codes, {5'd0, 5'd1, 5'd2, 5'd4});
    check_eq("c0124_fail", bus.fail_seen, 0);

    // Short dwell never captures
    do_reset(2);
    obs_pulses = 0;
    fr = {PatTab[7], PatTab[8], PatTab[9], PatTab[10]};
    repeat (4) scan_round(fr, Settle - 1);
    idle(4);
    check_eq("short_pulses", obs_pulses, 0);
    check_eq("short_digits", bus.digits, 28'hFFFFFFF);

    // Multi-low glitch: sticky error, frame still published
    do_reset(2);
    obs_pulses = 0;
    fr = {PatTab[5], PatTab[6], PatTab[7], PatTab[8]};
    scan_round(fr, 6);
    tick(4'b0011, 7'h00, 0);
    scan_round(fr, 6); scan_round(fr, 6); idle(4);
    check_eq("glitch_err", bus.anode_err, 1);
    check_eq("glitch_pulses", obs_pulses, 1);
    check_eq("glitch_codes", bus.codes, {5'd5, 5'd6, 5'd7, 5'd8});
    do_reset(1);
    check_eq("glitch_err_clr", bus.anode_err, 0);

    // Reset mid-frame restarts the stability count
    obs_pulses = 0;
    fr = {PatTab[12], PatTab[13], PatTab[14], PatTab[11]};
    scan_round(fr, 6); scan_round(fr, 6); idle(3);
    repeat (8) tick(an_sel(3), fr[27:21], 0);
    repeat (8) tick(an_sel(2), fr[20:14], 0);
    do_reset(2);
    check_eq("midrst_digits", bus.digits, 28'hFFFFFFF);
    obs_pulses = 0;
    scan_round(fr, 6); idle(4);
    check_eq("midrst_one_frame", obs_pulses, 0);
    scan_round(fr, 6); idle(4);
    check_eq("midrst_pulses", obs_pulses, 1);

    // Unknown pattern on digit 1
    fr = {PatTab[8], PatTab[9], 7'b0110110, PatTab[12]};
    scan_round(fr, 5); scan_round(fr, 5); idle(4);
    check_eq("bad_codes", bus.codes, {5'd8, 5'd9, 5'd31, 5'd12});

    // Random structured scans
    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 4; d++) begin
        fr[d*7 +: 7] = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                                   : PatTab[$urandom_range(0, 17)];
      end
      repeat ($urandom_range(1, 3)) begin
        for (int d = 3; d >= 0; d--) repeat ($urandom_range(3, 6)) tick(an_sel(d), fr[d*7 +: 7], 0);
      end
    end

    // Random anode/segment noise, including blanks, multi-low and resets
    for (int n = 0; n < 250; n++) begin
      int k = $urandom_range(0, 99);
      if (k < 80)      ra = an_sel($urandom_range(0, 3));
      else if (k < 90) ra = 4'hF;
      else begin
        ra = 4'($urandom);
        while ($countones(~ra) < 2) ra = 4'($urandom);
      end
      if (k == 99) do_reset(1);
      repeat ($urandom_range(1, 7)) tick(ra, PatTab[$urandom_range(0, 17)], 0);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive cycles one anode must be held before its cathodes are sampled (1..15).
REQ-002 Parameter STABLE_FRAMES, default 2: identical consecutive frames required before outputs update (1..7).
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 an  input  4  multiplexed anode bus, active-low; an[i]=0 selects digit i (digit 0 rightmost).
REQ-006 seg  input  7  cathode bus, active-low, seg[6:0]={g,f,e,d,c,b,a}.
REQ-007 digits  output  28  last accepted raw patterns, digits[7i+6:7i] = digit i.
REQ-008 codes  output  20  decoded character per digit, codes[5i+4:5i] = digit i.
REQ-009 frame_valid  output  1  one-cycle pulse when digits/codes update.
REQ-010 fail_seen  output  1  level; accepted frame reads F,A,I,L (digit3..digit0).
REQ-011 anode_err  output  1  sticky; set when more than one anode is low in a cycle.

Function
REQ-012 an and seg SHALL be registered once on entry; all later timing counts from this registered copy.
REQ-013 An anode dwell SHALL be tracked by a counter that restarts at 1 whenever the registered an changes; all-ones (blank) or multi-low an SHALL hold the counter at 0.
REQ-014 When the dwell counter of a single-low anode equals SETTLE_CYCLES, seg SHALL be captured once into shadow slot i and slot i marked captured; further cycles of the same dwell SHALL NOT recapture.
REQ-015 When all four slots are marked, the shadow frame SHALL complete in the next cycle: compared with the previous completed frame; match increments match_cnt (saturating at STABLE_FRAMES), mismatch sets it to 1; all capture marks clear.
REQ-016 When match_cnt reaches STABLE_FRAMES, and the frame differs from digits, digits and codes SHALL load and frame_valid SHALL pulse exactly one cycle; an identical repeated frame SHALL NOT re-pulse.
REQ-017 Capture latency SHALL be: an/seg change at cycle t, sample at t+SETTLE_CYCLES, frame completion one cycle after the fourth capture, outputs and frame_valid the following cycle.
REQ-018 Character decode SHALL map standard active-low hex patterns 0-F to codes 0-15 (0x7F0 family: 0=1000000, 1=1111001, A=0001000, F=0001110), L=1000111 to 16, all-off 1111111 to 17, anything else to 31.
REQ-019 fail_seen SHALL equal (codes == {F,A,1,L}) i.e. 15,10,1,16 on digits 3..0, updating only with codes.
REQ-020 anode_err SHALL set on any multi-low an cycle, SHALL clear only on reset, and that cycle SHALL NOT capture.
REQ-021 A digit captured twice before the frame completes (scan skipped another digit) SHALL overwrite its slot; completion still waits for all four marks.
REQ-022 Decode SHALL be purely combinational from the stored pattern; no arithmetic wider than the counters.

Reset
REQ-023 On reset: digits=all 1s (blank), codes=17 per digit, frame_valid=0, fail_seen=0, anode_err=0, dwell=0, match_cnt=0, capture marks and shadow cleared to blank.
REQ-024 Reset asserted mid-dwell or mid-frame SHALL discard partial captures; decoding restarts on the first anode change after release.

Structure
REQ-025 Shared package seg_pkg SHALL hold the 7-bit pattern constants (hex, L, blank) and the 5-bit character code constants.
REQ-026 One sub-module seg_char_decode (7-bit pattern in, 5-bit code out), instantiated four times.

Verification
REQ-027 Scan digits 3..0 with patterns F,A,I,L, 8 cycles each, two rounds -> one frame_valid pulse, codes={15,10,1,16}, fail_seen=1.
REQ-028 Scan 3,2,1,0 showing 0,1,2,3 then switch digit 0 to 4 -> first update 0,1,2,3; second update only after two full frames with 4; fail_seen=0.
REQ-029 Anode held 3 cycles (< SETTLE_CYCLES=4) per digit -> no capture, no frame_valid ever.
REQ-030 an=4'b0011 for one cycle during scan -> anode_err=1 and stays 1 until reset; outputs unaffected by that cycle.
REQ-031 Assert reset after two digits captured -> all outputs at reset values, next frame needs full STABLE_FRAMES.
REQ-032 Digit 1 pattern 0110110 -> code 31 for digit 1, others decoded normally.
